// File: rtl/div_pkg.sv
// ---------------------------------------------------------------------------
// div_pkg : shared constants for the EX-stage radix-2 divider.
// Revision: 1.0
// ---------------------------------------------------------------------------
`default_nettype none

package div_pkg;

    localparam logic [1:0] DivFree    = 2'b00;
    localparam logic [1:0] DivByZero  = 2'b01;
    localparam logic [1:0] DivOn      = 2'b10;
    localparam logic [1:0] DivEnd     = 2'b11;

    localparam logic DivResultReady    = 1'b1;
    localparam logic DivResultNotReady = 1'b0;
    localparam logic DivStart          = 1'b1;
    localparam logic DivStop           = 1'b0;
    localparam logic RstEnable         = 1'b1;

    localparam logic [31:0] ZeroWord   = 32'h0000_0000;

    localparam logic [7:0] EXE_DIV_OP  = 8'b0001_1010;
    localparam logic [7:0] EXE_DIVU_OP = 8'b0001_1011;

    typedef struct packed {
        logic [31:0] rem;
        logic [31:0] quo;
    } div_result_t;

endpackage

`default_nettype wire

// File: rtl/div_if.sv
// ---------------------------------------------------------------------------
// div_if : EX-stage request/response bundle between decode and divider.
// Revision: 1.0
// ---------------------------------------------------------------------------
`default_nettype none

interface div_if #(
    parameter int DATA_W = 32
);
    logic                  signed_div_i;
    logic [DATA_W-1:0]     opdata1_i;
    logic [DATA_W-1:0]     opdata2_i;
    logic                  start_i;
    logic                  annul_i;
    logic [2*DATA_W-1:0]   result_o;
    logic                  ready_o;

    modport master (
        output signed_div_i, opdata1_i, opdata2_i, start_i, annul_i,
        input  result_o, ready_o
    );

    modport slave (
        input  signed_div_i, opdata1_i, opdata2_i, start_i, annul_i,
        output result_o, ready_o
    );
endinterface

`default_nettype wire

// File: rtl/div.sv
// ---------------------------------------------------------------------------
// div : multi-cycle signed/unsigned restoring divider, one quotient bit/cycle.
// Revision: 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module div
    import div_pkg::*;
#(
    parameter int DATA_W = 32,
    parameter int CNT_W  = 6
) (
    input  logic  clk,
    input  logic  rst,
    div_if.slave  bus
);

    logic [1:0]          state;
    logic [CNT_W-1:0]    cnt;
    logic [2*DATA_W:0]   dividend;
    logic [DATA_W-1:0]   divisor;
    logic                qneg;
    logic                rneg;
    logic [2*DATA_W-1:0] result;
    logic                ready;

    logic                op1_neg;
    logic                op2_neg;
    logic [DATA_W-1:0]   op1_abs;
    logic [DATA_W-1:0]   op2_abs;
    logic [DATA_W:0]     trial;
    logic [DATA_W-1:0]   quo_fix;
    logic [DATA_W-1:0]   rem_fix;

    // dividend holds {partial_rem, dividend_shift} pre-shifted by one bit,
    // so the remainder ends up in [2W:W+1] and the quotient in [W-1:0].
    always_comb begin
        op1_neg = bus.signed_div_i & bus.opdata1_i[DATA_W-1];
        op2_neg = bus.signed_div_i & bus.opdata2_i[DATA_W-1];
        op1_abs = op1_neg ? -bus.opdata1_i : bus.opdata1_i;
        op2_abs = op2_neg ? -bus.opdata2_i : bus.opdata2_i;
        trial   = {1'b0, dividend[2*DATA_W-1:DATA_W]} - {1'b0, divisor};
        quo_fix = qneg ? -dividend[DATA_W-1:0] : dividend[DATA_W-1:0];
        rem_fix = rneg ? -dividend[2*DATA_W:DATA_W+1] : dividend[2*DATA_W:DATA_W+1];
    end

    always_ff @(posedge clk) begin
        if (rst == RstEnable) begin
            state    <= DivFree;
            cnt      <= '0;
            dividend <= '0;
            divisor  <= '0;
            qneg     <= 1'b0;
            rneg     <= 1'b0;
            result   <= '0;
            ready    <= DivResultNotReady;
        end else begin
            case (state)
                DivFree: begin
                    result <= '0;
                    ready  <= DivResultNotReady;
                    if (bus.start_i == DivStart && !bus.annul_i) begin
                        if (bus.opdata2_i == '0) begin
                            state <= DivByZero;
                        end else begin
                            dividend <= {{DATA_W{1'b0}}, op1_abs, 1'b0};
                            divisor  <= op2_abs;
                            qneg     <= op1_neg ^ op2_neg;
                            rneg     <= op1_neg;
                            cnt      <= '0;
                            state    <= DivOn;
                        end
                    end
                end
                DivByZero: begin
                    result <= '0;
                    ready  <= DivResultReady;
                    state  <= DivEnd;
                end
                DivOn: begin
                    if (bus.annul_i) begin
                        state <= DivFree;
                    end else if (cnt != CNT_W'(DATA_W)) begin
                        if (trial[DATA_W]) begin
                            dividend <= {dividend[2*DATA_W-1:0], 1'b0};
                        end else begin
                            dividend <= {trial[DATA_W-1:0], dividend[DATA_W-1:0], 1'b1};
                        end
                        cnt <= cnt + 1'b1;
                    end else begin
                        result <= {rem_fix, quo_fix};
                        ready  <= DivResultReady;
                        state  <= DivEnd;
                    end
                end
                DivEnd: begin
                    // Result is held until EX drops its request.
                    if (bus.start_i == DivStop) begin
                        result <= '0;
                        ready  <= DivResultNotReady;
                        state  <= DivFree;
                    end
                end
                default: state <= DivFree;
            endcase
        end
    end

    assign bus.result_o = result;
    assign bus.ready_o  = ready;

endmodule

`default_nettype wire

// File: tb/tb_div.sv
// ---------------------------------------------------------------------------
// tb_div : scoreboard bench for the EX-stage divider.
// Revision: 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module tb_div;
    import div_pkg::*;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   n_checks = 0;
    int   n_pass   = 0;
    logic [63:0] sb_q[$];

    div_if #(.DATA_W(32)) bus ();

    div #(.DATA_W(32), .CNT_W(6)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h", tag, got, exp);
    endtask

    function automatic logic [63:0] model(input logic s, input logic [31:0] a, input logic [31:0] b);
        longint sa, sv, q, r;
        if (b == 32'h0) return 64'h0;
        if (s) begin
            sa = longint'($signed(a));
            sv = longint'($signed(b));
        end else begin
            sa = longint'({32'h0, a});
            sv = longint'({32'h0, b});
        end
        q = sa / sv;
        r = sa % sv;
        return {r[31:0], q[31:0]};
    endfunction

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Launch one request, wait for ready, compare, hold, release.
    task automatic run_op(input logic s, input logic [31:0] a, input logic [31:0] b,
                          input int hold, input int chg_at);
        logic [63:0] exp_r;
        int lat_exp;
        int first_rdy;
        exp_r = model(s, a, b);
        sb_q.push_back(exp_r);
        lat_exp = (b == 32'h0) ? 1 : 33;
        bus.signed_div_i = s;
        bus.opdata1_i    = a;
        bus.opdata2_i    = b;
        bus.start_i      = 1'b1;
        bus.annul_i      = 1'b0;
        step();
        first_rdy = -1;
        for (int k = 1; k <= 40 && first_rdy < 0; k++) begin
            if (k == chg_at) begin
                bus.opdata1_i = ~a;
                bus.opdata2_i = b + 32'd3;
            end
            step();
            if (bus.ready_o) first_rdy = k;
        end
        check($sformatf("latency %h/%h", a, b), 64'(first_rdy), 64'(lat_exp));
        if (sb_q.size() > 0) check($sformatf("result %h/%h", a, b), bus.result_o, sb_q.pop_front());
        for (int k = 0; k < hold; k++) step();
        if (hold > 0) begin
            check("hold_result", bus.result_o, exp_r);
            check("hold_ready", 64'(bus.ready_o), 64'd1);
            check("hold_state", 64'(dut.state), 64'(DivEnd));
        end
        bus.start_i = 1'b0;
        step();
        check("release_ready", 64'(bus.ready_o), 64'd0);
        check("release_result", bus.result_o, 64'h0);
    endtask

    initial begin
        logic early;
        bus.signed_div_i = 1'b0;
        bus.opdata1_i    = 32'h0;
        bus.opdata2_i    = 32'h0;
        bus.start_i      = 1'b0;
        bus.annul_i      = 1'b0;
        step();
        step();
        check("reset_ready", 64'(bus.ready_o), 64'd0);
        check("reset_result", bus.result_o, 64'h0);
        check("reset_state", 64'(dut.state), 64'(DivFree));
        rst = 1'b0;
        step();

        run_op(1'b0, 32'd100, 32'd7, 0, 0);
        check("model_100_7", model(1'b0, 32'd100, 32'd7), {32'h2, 32'hE});
        run_op(1'b1, 32'hFFFF_FFF9, 32'h0000_0002, 0, 0);
        run_op(1'b1, 32'h0000_0007, 32'hFFFF_FFFE, 0, 0);
        run_op(1'b1, 32'd5, 32'd0, 0, 0);
        run_op(1'b0, 32'd5, 32'd0, 0, 0);
        run_op(1'b1, 32'h8000_0000, 32'hFFFF_FFFF, 0, 0);
        run_op(1'b0, 32'hFFFF_FFFF, 32'h0000_0010, 0, 0);
        run_op(1'b0, 32'd100, 32'd7, 10, 5);
        run_op(1'b1, 32'hFFFF_FF9C, 32'd7, 0, 5);

        // Annul at E10, then an immediate new request.
        bus.signed_div_i = 1'b0;
        bus.opdata1_i    = 32'd100;
        bus.opdata2_i    = 32'd7;
        bus.start_i      = 1'b1;
        step();
        early = 1'b0;
        for (int k = 1; k <= 9; k++) begin
            step();
            early |= bus.ready_o;
        end
        bus.annul_i = 1'b1;
        step();
        early |= bus.ready_o;
        bus.annul_i = 1'b0;
        check("annul_ready", 64'(early), 64'd0);
        check("annul_state", 64'(dut.state), 64'(DivFree));
        run_op(1'b0, 32'd100, 32'd7, 0, 0);

        // Reset at E20 mid-division.
        bus.opdata1_i = 32'd12345;
        bus.opdata2_i = 32'd11;
        bus.start_i   = 1'b1;
        step();
        for (int k = 1; k <= 19; k++) step();
        rst = 1'b1;
        step();
        check("midrst_ready", 64'(bus.ready_o), 64'd0);
        check("midrst_result", bus.result_o, 64'h0);
        check("midrst_state", 64'(dut.state), 64'(DivFree));
        rst = 1'b0;
        bus.start_i = 1'b0;
        early = 1'b0;
        for (int k = 0; k < 40; k++) begin
            step();
            early |= bus.ready_o;
        end
        check("midrst_no_result", 64'(early), 64'd0);

        for (int i = 0; i < 6; i++) begin
            run_op(1'($urandom_range(0, 1)), $urandom, $urandom >> $urandom_range(0, 31), 0, 0);
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

`default_nettype wire
